// File: rtl/security_monitor_mc.sv
// rtl/security_monitor_mc.sv - multi-channel copy-done monitor with per-channel watchdog and fault latch
// Optional latency capture: define SECMON_LAT_CAPTURE_EN to build the per-channel latency registers.
module security_monitor_mc #(
    parameter  int NUM_CH  = 4,
    parameter  int TMO_W   = 16,
    parameter  int TIMEOUT = 1000,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              aclk,
    input  logic              nreset,
    input  logic [NUM_CH-1:0] str_cpy,
    input  logic [NUM_CH-1:0] done_cpy,
    input  logic [NUM_CH-1:0] clr_fault,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] fault,
    output logic              irq,
    input  logic [SEL_W-1:0]  lat_sel,
    output logic [TMO_W-1:0]  lat_out
);

    if (NUM_CH < 1 || NUM_CH > 32 || TIMEOUT < 0 ||
        longint'(TIMEOUT) >= (longint'(1) << TMO_W)) begin : g_bad_param
        $error("security_monitor_mc: NUM_CH must be 1..32 and TIMEOUT < 2**TMO_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Counter value on the last BUSY cycle before the watchdog fires.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] CNT_MAX  = '1;

    state_t            state    [NUM_CH];
    state_t            state_nx [NUM_CH];
    logic [TMO_W-1:0]  cnt      [NUM_CH];
    logic [NUM_CH-1:0] ev_done;
    logic [NUM_CH-1:0] ev_fault;

    // Next-state decode per channel; FAULT is absorbing until cleared, done_cpy beats str_cpy elsewhere.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nx[i] = state[i];
            ev_done[i]  = 1'b0;
            ev_fault[i] = 1'b0;
            if (state[i] == ST_FAULT) begin
                if (clr_fault[i]) begin
                    state_nx[i] = ST_IDLE;
                end
            end else if (done_cpy[i]) begin
                state_nx[i] = ST_DONE;
                ev_done[i]  = (state[i] != ST_DONE);
            end else begin
                case (state[i])
                    ST_IDLE: begin
                        if (str_cpy[i]) begin
                            state_nx[i] = ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (!str_cpy[i]) begin
                            state_nx[i] = ST_IDLE;
                        end else if (TIMEOUT != 0 && cnt[i] == TMO_LAST) begin
                            state_nx[i] = ST_FAULT;
                            ev_fault[i] = 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!str_cpy[i]) begin
                            state_nx[i] = ST_IDLE;
                        end
                    end
                    default: state_nx[i] = state[i];
                endcase
            end
        end
    end

    // Channel state, watchdog counters and the aggregated interrupt pulse.
    always_ff @(posedge aclk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= ST_IDLE;
                cnt[i]   <= '0;
            end
            irq <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nx[i];
                if (state[i] == ST_IDLE && state_nx[i] == ST_BUSY) begin
                    cnt[i] <= '0;
                end else if (state[i] == ST_BUSY && state_nx[i] == ST_BUSY && cnt[i] != CNT_MAX) begin
                    // Saturate so an unbounded (watchdog-off) copy never wraps the counter.
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            irq <= |(ev_done | ev_fault);
        end
    end

    // Status flags are a straight decode of the state register.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            done[i]  = (state[i] == ST_DONE);
            busy[i]  = (state[i] == ST_BUSY);
            fault[i] = (state[i] == ST_FAULT);
        end
    end

`ifdef SECMON_LAT_CAPTURE_EN
    logic [TMO_W-1:0] lat [NUM_CH];

    // Capture BUSY duration on completion; a completion straight from IDLE records zero.
    always_ff @(posedge aclk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                lat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ev_done[i]) begin
                    if (state[i] == ST_BUSY) begin
                        lat[i] <= (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 1'b1;
                    end else begin
                        lat[i] <= '0;
                    end
                end
            end
        end
    end

    // Readback mux; out-of-range selects read as zero.
    always_comb begin
        lat_out = '0;
        if (int'(lat_sel) < NUM_CH) begin
            lat_out = lat[lat_sel];
        end
    end
`else
    logic unused_lat_sel;

    // No latency storage in this build.
    always_comb begin
        lat_out        = '0;
        unused_lat_sel = ^lat_sel;
    end
`endif

endmodule

// File: tb/tb_security_monitor_mc.sv
// tb/tb_security_monitor_mc.sv - randomized bench for security_monitor_mc against a behavioural model
module tb_security_monitor_mc;

    localparam int NCH = 4;
    localparam int TMO = 8;

    logic        aclk;
    logic        nreset;
    logic [3:0]  str_cpy, done_cpy, clr_fault;
    logic [1:0]  lat_sel;
    logic [3:0]  done, busy, fault;
    logic        irq;
    logic [15:0] lat_out;

    logic [3:0]  str_b, done_b, clr_b;
    logic [1:0]  sel_b;
    logic [3:0]  done_o_b, busy_o_b, fault_o_b;
    logic        irq_b;
    logic [15:0] lat_b;

    int checks = 0;
    int errors = 0;

    security_monitor_mc #(.NUM_CH(NCH), .TMO_W(16), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .nreset(nreset), .str_cpy(str_cpy), .done_cpy(done_cpy),
        .clr_fault(clr_fault), .done(done), .busy(busy), .fault(fault), .irq(irq),
        .lat_sel(lat_sel), .lat_out(lat_out)
    );

    security_monitor_mc #(.NUM_CH(NCH), .TMO_W(16), .TIMEOUT(0)) dut_nowd (
        .aclk(aclk), .nreset(nreset), .str_cpy(str_b), .done_cpy(done_b),
        .clr_fault(clr_b), .done(done_o_b), .busy(busy_o_b), .fault(fault_o_b), .irq(irq_b),
        .lat_sel(sel_b), .lat_out(lat_b)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Behavioural model: activity flags plus the edge index at which the copy started.
    bit m_busy [NCH];
    bit m_done [NCH];
    bit m_fault[NCH];
    int m_start[NCH];
    int m_lat  [NCH];
    bit m_irq;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_fault[i] = 0; m_start[i] = 0; m_lat[i] = 0;
        end
        m_irq = 0;
    endtask

    task automatic model_step();
        bit ev;
        int el;
        ev = 0;
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            if (m_fault[i]) begin
                if (clr_fault[i]) m_fault[i] = 0;
            end else if (done_cpy[i]) begin
                if (!m_done[i]) begin
                    ev = 1;
                    el = m_busy[i] ? cyc - m_start[i] : 0;
                    m_lat[i] = (el > 65535) ? 65535 : el;
                end
                m_done[i] = 1;
                m_busy[i] = 0;
            end else if (m_busy[i]) begin
                if (!str_cpy[i]) begin
                    m_busy[i] = 0;
                end else if (cyc - m_start[i] == TMO) begin
                    m_busy[i]  = 0;
                    m_fault[i] = 1;
                    ev = 1;
                end
            end else if (m_done[i]) begin
                if (!str_cpy[i]) m_done[i] = 0;
            end else if (str_cpy[i]) begin
                m_busy[i]  = 1;
                m_start[i] = cyc;
            end
        end
        m_irq = ev;
    endtask

    task automatic compare_all();
        logic [3:0] ed, eb, ef;
        int el;
        for (int i = 0; i < NCH; i++) begin
            ed[i] = m_done[i]; eb[i] = m_busy[i]; ef[i] = m_fault[i];
        end
`ifdef SECMON_LAT_CAPTURE_EN
        el = m_lat[lat_sel];
`else
        el = 0;
`endif
        check("done", 32'(done), 32'(ed));
        check("busy", 32'(busy), 32'(eb));
        check("fault", 32'(fault), 32'(ef));
        check("irq", 32'(irq), m_irq ? 1 : 0);
        check("lat_out", 32'(lat_out), el);
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] d, input logic [3:0] c,
                        input logic [1:0] sel);
        @(negedge aclk);
        str_cpy = s; done_cpy = d; clr_fault = c; lat_sel = sel;
        @(posedge aclk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [3:0] s, d, c;
        int el;
        nreset = 1'b0;
        str_cpy = '0; done_cpy = '0; clr_fault = '0; lat_sel = '0;
        str_b = '0; done_b = '0; clr_b = '0; sel_b = '0;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_irq", 32'(irq), 0);
        @(negedge aclk);
        nreset = 1'b1;

        // Normal copy on channel 0, done at edge 3.
        step(4'b0001, 4'b0000, 4'b0000, 2'd0);
        check("norm_busy", 32'(busy[0]), 1);
        step(4'b0001, 4'b0000, 4'b0000, 2'd0);
        step(4'b0001, 4'b0000, 4'b0000, 2'd0);
        step(4'b0001, 4'b0001, 4'b0000, 2'd0);
        check("norm_done", 32'(done[0]), 1);
        check("norm_irq", 32'(irq), 1);
`ifdef SECMON_LAT_CAPTURE_EN
        check("norm_lat", 32'(lat_out), 3);
`else
        check("norm_lat", 32'(lat_out), 0);
`endif
        step(4'b0001, 4'b0000, 4'b0000, 2'd0);
        check("norm_irq_once", 32'(irq), 0);
        check("norm_hold", 32'(done[0]), 1);
        step(4'b0000, 4'b0000, 4'b0000, 2'd0);
        check("norm_release", 32'(done[0]), 0);

        // Watchdog on channel 1.
        for (int k = 0; k <= TMO; k++) begin
            step(4'b0010, 4'b0000, 4'b0000, 2'd1);
            check("tmo_fault", 32'(fault[1]), (k == TMO) ? 1 : 0);
            check("tmo_irq", 32'(irq), (k == TMO) ? 1 : 0);
        end
        step(4'b0010, 4'b0010, 4'b0000, 2'd1);
        check("tmo_done_ignored", 32'(done[1]), 0);
        check("tmo_still_fault", 32'(fault[1]), 1);
        step(4'b0000, 4'b0000, 4'b0010, 2'd1);
        check("tmo_cleared", 32'(fault[1]), 0);
        check("tmo_idle", 32'(busy[1]), 0);

        // Simultaneous completion from IDLE on channels 2 and 3.
        step(4'b0000, 4'b1100, 4'b0000, 2'd3);
        check("sim_done", 32'(done[3:2]), 3);
        check("sim_irq", 32'(irq), 1);
        step(4'b0000, 4'b0000, 4'b0000, 2'd3);
        check("sim_irq_once", 32'(irq), 0);

        // Abort on channel 2.
        for (int k = 0; k < 3; k++) step(4'b0100, 4'b0000, 4'b0000, 2'd2);
        check("abort_busy", 32'(busy[2]), 1);
        step(4'b0000, 4'b0000, 4'b0000, 2'd2);
        check("abort_busy_fall", 32'(busy[2]), 0);
        check("abort_done", 32'(done[2]), 0);
        check("abort_fault", 32'(fault[2]), 0);
        check("abort_irq", 32'(irq), 0);

        // Randomized traffic with an asynchronous reset pulse in the middle.
        s = '0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                @(posedge aclk);
                #2;
                nreset = 1'b0;
                #1;
                check("arst_done", 32'(done), 0);
                check("arst_busy", 32'(busy), 0);
                check("arst_fault", 32'(fault), 0);
                check("arst_irq", 32'(irq), 0);
                check("arst_lat", 32'(lat_out), 0);
                model_reset();
                @(negedge aclk);
                str_cpy = '0; done_cpy = '0; clr_fault = '0; s = '0;
                nreset = 1'b1;
                @(posedge aclk);
                model_step();
                #1;
                compare_all();
            end
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 5) == 0) s[i] = ~s[i];
                d[i] = ($urandom_range(0, 11) == 0);
                c[i] = ($urandom_range(0, 3) == 0);
            end
            step(s, d, c, 2'($urandom_range(0, 3)));
        end

        // Watchdog disabled: a copy held far beyond the counter range never faults.
        @(negedge aclk);
        str_cpy = '0; done_cpy = '0; clr_fault = '0;
        str_b = 4'b0001;
        @(posedge aclk);
        for (int k = 1; k <= 70000; k++) begin
            @(posedge aclk);
            if (k % 7000 == 0) begin
                #1;
                check("nowd_busy", 32'(busy_o_b[0]), 1);
                check("nowd_fault", 32'(fault_o_b[0]), 0);
            end
        end
        @(negedge aclk);
        done_b = 4'b0001;
        @(posedge aclk);
        #1;
        check("nowd_done", 32'(done_o_b[0]), 1);
        check("nowd_irq", 32'(irq_b), 1);
`ifdef SECMON_LAT_CAPTURE_EN
        el = 65535;
`else
        el = 0;
`endif
        check("nowd_lat_sat", 32'(lat_b), el);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
